// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and types for the multiply/divide unit
// Contents: default operand width, funct codes handled by the unit,
//           FSM state encoding, and a helper that recognises long ops.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Multi-cycle ops: the ones that stall the pipeline.
  function automatic logic is_long_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - iterative shift-add multiply / restoring divide datapath
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   load                : capture operand magnitudes, signs and mode
//   step                : perform one multiply or divide iteration
//   div_op, signed_op   : mode of the op being loaded (sampled on load)
//   div_zero            : select the divide-by-zero result pattern
//   a, b                : raw rs / rt operands
//   res_hi, res_lo      : sign-corrected results destined for HI / LO
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div_op,
  input  logic             signed_op,
  input  logic             div_zero,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc_hi/acc_lo form one 2*WIDTH accumulator shared by both modes:
  //   multiply: {partial product high, multiplier shifting out / product low}
  //   divide  : {partial remainder, dividend shifting out / quotient in}
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_raw;      // rs as presented, for the divide-by-zero HI value
  logic             mode_div;
  logic             sign_main;  // product sign or quotient sign
  logic             sign_rem;   // remainder follows the dividend

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    a_mag = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // One extra bit on the adder so the carry into the shifted-in bit survives.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

    // Restoring trial subtract; bit WIDTH+1 is the borrow (negative result).
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};

    product  = {acc_hi, acc_lo};
    prod_fix = sign_main ? (~product + (2*WIDTH)'(1)) : product;
    quot_fix = sign_main ? (~acc_lo + WIDTH'(1)) : acc_lo;
    rem_fix  = sign_rem  ? (~acc_hi + WIDTH'(1)) : acc_hi;

    if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else if (mode_div) begin
      res_hi = rem_fix;
      res_lo = quot_fix;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      a_raw     <= '0;
      mode_div  <= 1'b0;
      sign_main <= 1'b0;
      sign_rem  <= 1'b0;
    end else if (load) begin
      acc_hi    <= '0;
      acc_lo    <= div_op ? a_mag : b_mag;
      opnd      <= div_op ? b_mag : a_mag;
      a_raw     <= a;
      mode_div  <= div_op;
      sign_main <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      sign_rem  <= signed_op & a[WIDTH-1];
    end else if (step) begin
      if (mode_div) begin
        if (!div_diff[WIDTH+1]) begin
          acc_hi <= div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MIPS multiply/divide unit with HI/LO registers
// Ports:
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   op_valid        : decoder says this R-type instruction targets the unit
//   funct           : instruction funct field
//   Read_A, Read_B  : rs / rt operand values
//   stall           : combinational hold request for PC / IF
//   busy            : FSM is not idle
//   done            : one-cycle pulse, HI/LO just updated by mul/div
//   div_by_zero     : one-cycle pulse alongside done for a zero divisor
//   hi, lo          : HI / LO architectural registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] Read_A,
  input  logic [WIDTH-1:0] Read_B,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             dz_pending;

  logic             long_op;
  logic             op_div;
  logic             op_signed;
  logic             b_zero;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign long_op   = op_valid & is_long_op(funct);
  assign op_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign b_zero    = (Read_B == '0);

  assign busy = (state != S_IDLE);

  // The ~done term releases the stall in the done cycle and keeps the
  // still-present instruction from being accepted a second time.
  assign stall = busy | (long_op & ~done);

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (long_op && !done) begin
          load = 1'b1;
          if (op_div) next_state = b_zero ? S_FIN : S_DIV;
          else        next_state = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        step = 1'b1;
        if (count == '0) next_state = S_FIN;
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      dz_pending  <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state       <= next_state;
      done        <= 1'b0;
      div_by_zero <= 1'b0;

      if (load) begin
        count      <= CNT_W'(WIDTH - 1);
        dz_pending <= op_div & b_zero;
      end else if (step && count != '0) begin
        count <= count - CNT_W'(1);
      end

      if (state == S_IDLE && op_valid) begin
        if (funct == FUNCT_MTHI) hi <= Read_A;
        if (funct == FUNCT_MTLO) lo <= Read_A;
      end

      if (state == S_FIN) begin
        hi          <= res_hi;
        lo          <= res_lo;
        done        <= 1'b1;
        div_by_zero <= dz_pending;
        dz_pending  <= 1'b0;
      end
    end
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .div_op    (op_div),
    .signed_op (op_signed),
    .div_zero  (dz_pending),
    .a         (Read_A),
    .b         (Read_B),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

endmodule
